l2_responder: RTL and testbench
===============================

Name: l2_responder

Overview:
- Next-level (L2) cache that services line requests issued by the L1 instruction and data caches over the 2-bit command / 26-bit line-address interface.
- It is the responder end of the L1 READ_OUT protocol.
- 2-way set-associative with one LRU bit per set and per-way valid/dirty/tag.
- Misses are serviced by a fixed-latency backing-memory model; dirty victims cost an extra write-back delay.
- Sits between the L1 caches and the statistics module.

Parameters:
- SET_BITS, 10, index width; sets = 2**SET_BITS.
- TAG_BITS, 26-SET_BITS, tag width taken from the upper line-address bits.
- MEM_LATENCY, 4, backing-memory cycles per line transfer (>=1).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- cmd_in  in  2  00 idle, 01 READ, 10 WRITE (L1 write-back), 11 INVAL
- add_in  in  26  line address; index = add_in[SET_BITS-1:0], tag = add_in[25:SET_BITS]
- ready  out  1  high only in IDLE; a command is accepted when ready=1 and cmd_in!=00
- resp_valid  out  1  one-cycle completion pulse
- resp_hit  out  1  lookup result for the completed request; valid with resp_valid
- resp_add  out  26  echo of the accepted address; valid with resp_valid
- mem_busy  out  1  high while the backing-memory model is counting
- hit, miss, writebacks  out  32 each  statistics counters

Behaviour:
- Reset (asynchronous, any state):
  - Outputs: state IDLE, ready=1, resp_valid=0, resp_hit=0, resp_add=0, mem_busy=0.
  - Arrays: all valid, dirty and LRU bits cleared; counters cleared.
  - Any in-flight request is dropped with no response.
- Registered outputs. FSM states: IDLE, LOOKUP, WB_WAIT, MEM_WAIT, RESP.
- IDLE:
  - On accept at edge E0: latch cmd and address, go to LOOKUP, ready=0.
  - cmd_in is ignored whenever ready=0; L1 must hold its command until it sees ready.
- LOOKUP (edge E1): compare both ways; hit = tag match and valid.
  - READ hit: LRU := other way; go to RESP.
  - WRITE hit: set dirty; LRU := other way; go to RESP.
  - INVAL: clear valid and dirty of the matching way, leave LRU unchanged, resp_hit=match; go to RESP. INVAL never touches memory and never counts hit or miss.
  - READ/WRITE miss: pick the victim, lowest-numbered invalid way first, else way LRU[index].
    - Victim valid and dirty: go to WB_WAIT with cnt := MEM_LATENCY-1, writebacks+1.
    - Otherwise: go to MEM_WAIT with cnt := MEM_LATENCY-1.
- WB_WAIT: decrement cnt each edge; at cnt==0 go to MEM_WAIT with cnt reloaded.
- MEM_WAIT: decrement each edge; at cnt==0 fill the victim (tag, valid=1, dirty = (cmd==WRITE)), set LRU := other way, go to RESP.
- mem_busy is high exactly during WB_WAIT and MEM_WAIT.
- RESP: resp_valid=1 for one cycle; next edge goes to IDLE with ready=1. resp_valid and ready are never high together.
- Latency, accept edge to resp_valid high:
  - Hit or INVAL: 2 edges.
  - Clean miss: 2 + MEM_LATENCY edges.
  - Dirty-victim miss: 2 + 2*MEM_LATENCY edges.
- Counters: hit/miss update at the LOOKUP edge for READ/WRITE only. They wrap modulo 2**32 with no saturation.
- Boundaries:
  - Index 0 and index 2**SET_BITS-1 behave identically.
  - All-ones tag is a legal tag.
  - A request to the same line as the previous fill hits.

Optional Feature:
- L2_PRINT_EN
  - Defined: adds input print (1 bit). A rising edge of print while in IDLE $displays every set with any valid way: index, LRU, V/D/tag per way. Printing does not change state and takes zero extra cycles.
  - Undefined: the print port and all $display code are absent; behaviour is otherwise identical.

Decomposition:
- Shared package l2_pkg:
  - Command encodings CMD_IDLE/CMD_READ/CMD_WRITE/CMD_INVAL; these are shared with the L1 caches.
  - FSM state enum.
  - Line-address width constant 26.
- Sub-module l2_mem_model: down-counter with load/busy/done outputs, used for both WB_WAIT and MEM_WAIT.

Test Plan (SET_BITS=4, MEM_LATENCY=4):
- Reset, then READ 0x0000010 → miss=1, resp_hit=0, resp_valid exactly 6 edges after accept; a repeat READ → hit=1, resp_valid at 2 edges.
- READ tags A, B, then A, then C, all at index 3 → C evicts B (LRU); a following READ B misses; miss=4, hit=1.
- WRITE to fill way 0, READ to fill way 1, then force eviction of the dirty line → writebacks=1, latency 10 edges, mem_busy high for 8 cycles.
- INVAL of a present line → resp_hit=1, next READ misses; INVAL of an absent line → resp_hit=0, counters unchanged.
- Assert rst during MEM_WAIT → ready=1 and resp_valid=0 immediately, no response issued; a later READ of the same line misses.
- Toggle cmd_in while ready=0 → the extra commands are ignored; exactly one resp_valid pulse per accepted command.

Source files
------------

// File: rtl/l2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : l2_pkg
// Purpose  : Definitions shared by the L2 responder and the L1 caches.
//            Holds the command encodings, the line-address width, the FSM
//            state enumeration and a small command-decode helper.
// Revision : 1.0 - initial release
// ============================================================================
package l2_pkg;

  // Line address width on the L1 <-> L2 interface.
  localparam int ADDR_W = 26;

  // Command encodings; the L1 caches use the same values.
  typedef enum logic [1:0] {
    CMD_IDLE  = 2'b00,
    CMD_READ  = 2'b01,
    CMD_WRITE = 2'b10,
    CMD_INVAL = 2'b11
  } l2_cmd_e;

  // Responder FSM states.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOOKUP   = 3'd1,
    ST_WB_WAIT  = 3'd2,
    ST_MEM_WAIT = 3'd3,
    ST_RESP     = 3'd4
  } l2_state_e;

  // READ and WRITE are the only commands that allocate and count hit/miss.
  function automatic logic cmd_is_rw(input logic [1:0] cmd);
    return (cmd == CMD_READ) || (cmd == CMD_WRITE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/l2_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : l2_responder_if
// Purpose  : Request/response bundle between an L1 cache (master) and the
//            L2 responder (slave).
// Signals  : cmd_in[1:0]  command from L1 (held until ready)
//            add_in[25:0] line address from L1
//            ready        responder can accept a command
//            resp_valid   one-cycle completion pulse
//            resp_hit     lookup result, valid with resp_valid
//            resp_add     echoed address, valid with resp_valid
// Revision : 1.0 - initial release
// ============================================================================
interface l2_responder_if;
  import l2_pkg::*;

  logic [1:0]        cmd_in;
  logic [ADDR_W-1:0] add_in;
  logic              ready;
  logic              resp_valid;
  logic              resp_hit;
  logic [ADDR_W-1:0] resp_add;

  modport master (
    output cmd_in, add_in,
    input  ready, resp_valid, resp_hit, resp_add
  );

  modport slave (
    input  cmd_in, add_in,
    output ready, resp_valid, resp_hit, resp_add
  );

endinterface
`default_nettype wire

// File: rtl/l2_mem_model.sv
`default_nettype none
// ============================================================================
// Module   : l2_mem_model
// Purpose  : Fixed-latency backing-memory timer. A load starts a transfer of
//            LATENCY cycles; done is asserted in the last cycle. A load in
//            the done cycle chains a second transfer without a gap, which is
//            how a write-back is followed by the line fill.
// Ports    : clk, rst   clock, asynchronous active-high reset
//            i_load     start (or restart) a transfer
//            o_busy     transfer in progress (registered)
//            o_done     final cycle of the current transfer
// Revision : 1.0 - initial release
// ============================================================================
module l2_mem_model #(
  parameter int LATENCY = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  output logic o_busy,
  output logic o_done
);

  localparam int               c_cnt_w  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [c_cnt_w-1:0] c_reload = c_cnt_w'(LATENCY - 1);

  logic [c_cnt_w-1:0] r_cnt;
  logic               r_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_load) begin
      r_cnt  <= c_reload;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      if (r_cnt == '0) begin
        r_busy <= 1'b0;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_busy && (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/l2_responder.sv
`default_nettype none
// ============================================================================
// Module   : l2_responder
// Purpose  : 2-way set-associative L2 cache answering L1 line requests.
//            One LRU bit per set, per-way valid/dirty/tag. Misses wait on a
//            fixed-latency memory model; dirty victims add a write-back wait.
// Ports    : clk, rst     clock, asynchronous active-high reset
//            print        (L2_PRINT_EN only) rising edge in IDLE dumps sets
//            bus          l2_responder_if.slave request/response bundle
//            mem_busy     memory model active (WB_WAIT or MEM_WAIT)
//            hit, miss    READ/WRITE lookup counters (wrap at 2**32)
//            writebacks   dirty-victim eviction counter
// Options  : `define L2_PRINT_EN adds the print port and set dump.
// Revision : 1.0 - initial release
// ============================================================================
module l2_responder
  import l2_pkg::*;
#(
  parameter  int SET_BITS    = 10,
  parameter  int MEM_LATENCY = 4,
  localparam int TAG_BITS    = ADDR_W - SET_BITS
) (
  input  logic          clk,
  input  logic          rst,
`ifdef L2_PRINT_EN
  input  logic          print,
`endif
  l2_responder_if.slave bus,
  output logic          mem_busy,
  output logic [31:0]   hit,
  output logic [31:0]   miss,
  output logic [31:0]   writebacks
);

  localparam int         c_sets        = 1 << SET_BITS;
  localparam logic [2:0] c_st_idle     = ST_IDLE;
  localparam logic [2:0] c_st_lookup   = ST_LOOKUP;
  localparam logic [2:0] c_st_wb_wait  = ST_WB_WAIT;
  localparam logic [2:0] c_st_mem_wait = ST_MEM_WAIT;
  localparam logic [2:0] c_st_resp     = ST_RESP;

  // Cache state. LRU holds the way to evict next.
  logic [1:0]          r_valid [c_sets];
  logic [1:0]          r_dirty [c_sets];
  logic [c_sets-1:0]   r_lru;
  logic [TAG_BITS-1:0] r_tag   [c_sets][2];

  logic [2:0]          r_state;
  logic [1:0]          r_cmd;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_victim;
  logic                r_ready;
  logic                r_resp_valid;
  logic                r_resp_hit;
  logic [ADDR_W-1:0]   r_resp_add;
  logic [31:0]         r_hit_cnt;
  logic [31:0]         r_miss_cnt;
  logic [31:0]         r_wb_cnt;

  logic [SET_BITS-1:0] w_idx;
  logic [TAG_BITS-1:0] w_tag;
  logic [1:0]          w_match;
  logic                w_hit;
  logic                w_hit_way;
  logic                w_victim;
  logic                w_victim_dirty;
  logic                w_mem_load;
  logic                w_mem_busy;
  logic                w_mem_done;
  logic                w_fill;

  assign w_idx = r_addr[SET_BITS-1:0];
  assign w_tag = r_addr[ADDR_W-1:SET_BITS];

  genvar gw;
  for (gw = 0; gw < 2; gw++) begin : g_way
    assign w_match[gw] = r_valid[w_idx][gw] && (r_tag[w_idx][gw] == w_tag);
  end

  assign w_hit     = |w_match;
  assign w_hit_way = w_match[0] ? 1'b0 : 1'b1;

  // Victim: lowest-numbered invalid way first, otherwise the LRU way.
  assign w_victim = !r_valid[w_idx][0] ? 1'b0 :
                    !r_valid[w_idx][1] ? 1'b1 : r_lru[w_idx];
  assign w_victim_dirty = r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim];

  // The timer is loaded on the miss decision and reloaded when the
  // write-back phase finishes, so the fill follows without a gap.
  assign w_mem_load = ((r_state == c_st_lookup) && cmd_is_rw(r_cmd) && !w_hit) ||
                      ((r_state == c_st_wb_wait) && w_mem_done);
  assign w_fill     = (r_state == c_st_mem_wait) && w_mem_done;

  l2_mem_model #(
    .LATENCY (MEM_LATENCY)
  ) u_mem (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_mem_load),
    .o_busy (w_mem_busy),
    .o_done (w_mem_done)
  );

  // Control FSM and statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= c_st_idle;
      r_cmd        <= CMD_IDLE;
      r_addr       <= '0;
      r_victim     <= 1'b0;
      r_ready      <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_hit   <= 1'b0;
      r_resp_add   <= '0;
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
      r_wb_cnt     <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (bus.cmd_in != CMD_IDLE) begin
            r_cmd   <= bus.cmd_in;
            r_addr  <= bus.add_in;
            r_ready <= 1'b0;
            r_state <= c_st_lookup;
          end
        end
        c_st_lookup: begin
          if (r_cmd == CMD_INVAL || w_hit) begin
            if (r_cmd != CMD_INVAL) r_hit_cnt <= r_hit_cnt + 1'b1;
            r_resp_valid <= 1'b1;
            r_resp_hit   <= w_hit;
            r_resp_add   <= r_addr;
            r_state      <= c_st_resp;
          end else begin
            r_miss_cnt <= r_miss_cnt + 1'b1;
            r_victim   <= w_victim;
            if (w_victim_dirty) begin
              r_wb_cnt <= r_wb_cnt + 1'b1;
              r_state  <= c_st_wb_wait;
            end else begin
              r_state <= c_st_mem_wait;
            end
          end
        end
        c_st_wb_wait: begin
          if (w_mem_done) r_state <= c_st_mem_wait;
        end
        c_st_mem_wait: begin
          if (w_mem_done) begin
            r_resp_valid <= 1'b1;
            r_resp_hit   <= 1'b0;
            r_resp_add   <= r_addr;
            r_state      <= c_st_resp;
          end
        end
        c_st_resp: begin
          r_resp_valid <= 1'b0;
          r_ready      <= 1'b1;
          r_state      <= c_st_idle;
        end
        default: begin
          r_resp_valid <= 1'b0;
          r_ready      <= 1'b1;
          r_state      <= c_st_idle;
        end
      endcase
    end
  end

  // Valid/dirty/LRU arrays.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < c_sets; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
      end
      r_lru <= '0;
    end else if (r_state == c_st_lookup) begin
      if (r_cmd == CMD_INVAL) begin
        // INVAL leaves the LRU bit alone.
        for (int w = 0; w < 2; w++) begin
          if (w_match[w]) begin
            r_valid[w_idx][w] <= 1'b0;
            r_dirty[w_idx][w] <= 1'b0;
          end
        end
      end else if (w_hit) begin
        r_lru[w_idx] <= ~w_hit_way;
        if (r_cmd == CMD_WRITE) r_dirty[w_idx][w_hit_way] <= 1'b1;
      end
    end else if (w_fill) begin
      r_valid[w_idx][r_victim] <= 1'b1;
      r_dirty[w_idx][r_victim] <= (r_cmd == CMD_WRITE);
      r_lru[w_idx]             <= ~r_victim;
    end
  end

  // Tags are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (w_fill) r_tag[w_idx][r_victim] <= w_tag;
  end

`ifdef L2_PRINT_EN
  logic r_print_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_print_d <= 1'b0;
    else     r_print_d <= print;
  end

  always_ff @(posedge clk) begin
    if (!rst && print && !r_print_d && r_state == c_st_idle) begin
      for (int s = 0; s < c_sets; s++) begin
        if (r_valid[s] != 2'b00) begin
          $display("L2 set %0d lru=%0d | w0 V=%0d D=%0d tag=%0h | w1 V=%0d D=%0d tag=%0h",
                   s, r_lru[s], r_valid[s][0], r_dirty[s][0], r_tag[s][0],
                   r_valid[s][1], r_dirty[s][1], r_tag[s][1]);
        end
      end
    end
  end
`else
  // Set dump compiled out.
`endif

  assign bus.ready      = r_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_hit   = r_resp_hit;
  assign bus.resp_add   = r_resp_add;
  assign mem_busy       = w_mem_busy;
  assign hit            = r_hit_cnt;
  assign miss           = r_miss_cnt;
  assign writebacks     = r_wb_cnt;

endmodule
`default_nettype wire

// File: tb/tb_l2_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_l2_responder
// Purpose  : Self-checking bench for l2_responder (SET_BITS=4, MEM_LATENCY=4):
//            a directed vector table, reset/ignore-command sequences, and a
//            random phase compared against a recency-based cache model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l2_responder;
  import l2_pkg::*;

  localparam int SB  = 4;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_busy;
  logic [31:0] hit, miss, writebacks;
`ifdef L2_PRINT_EN
  logic        print = 1'b0;
`endif

  l2_responder_if bus();

  l2_responder #(.SET_BITS(SB), .MEM_LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef L2_PRINT_EN
    .print      (print),
`endif
    .bus        (bus),
    .mem_busy   (mem_busy),
    .hit        (hit),
    .miss       (miss),
    .writebacks (writebacks)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // resp_valid and ready must never be high together.
  always @(negedge clk) begin
    if (!rst && bus.resp_valid) check("resp_valid_vs_ready", {63'd0, bus.ready}, 64'd0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [25:0] mk(input logic [21:0] tag, input logic [3:0] idx);
    return {tag, idx};
  endfunction

  // ---------------- reference model ----------------
  // Each set keeps up to two lines with a last-touched stamp; eviction takes
  // any empty slot, otherwise the line touched longest ago.
  logic        m_v   [16][2];
  logic        m_d   [16][2];
  logic [21:0] m_t   [16][2];
  int          m_age [16][2];
  int          m_stamp;
  logic [31:0] m_hit, m_miss, m_wb;

  task automatic model_reset();
    for (int s = 0; s < 16; s++)
      for (int w = 0; w < 2; w++) begin
        m_v[s][w] = 1'b0; m_d[s][w] = 1'b0; m_t[s][w] = '0; m_age[s][w] = 0;
      end
    m_stamp = 0; m_hit = 0; m_miss = 0; m_wb = 0;
  endtask

  task automatic model_access(input logic [1:0] cmd, input logic [25:0] addr,
                              output logic e_hit, output int e_lat, output int e_busy);
    int s, found, slot;
    s = int'(addr[3:0]);
    found = -1;
    for (int w = 0; w < 2; w++) if (m_v[s][w] && m_t[s][w] == addr[25:4]) found = w;
    e_hit = (found >= 0); e_lat = 2; e_busy = 0;
    if (cmd == CMD_INVAL) begin
      if (found >= 0) begin m_v[s][found] = 1'b0; m_d[s][found] = 1'b0; end
    end else if (found >= 0) begin
      m_hit++;
      m_stamp++; m_age[s][found] = m_stamp;
      if (cmd == CMD_WRITE) m_d[s][found] = 1'b1;
    end else begin
      m_miss++;
      if (!m_v[s][0])      slot = 0;
      else if (!m_v[s][1]) slot = 1;
      else                 slot = (m_age[s][0] < m_age[s][1]) ? 0 : 1;
      e_busy = LAT;
      if (m_v[s][slot] && m_d[s][slot]) begin m_wb++; e_busy = 2 * LAT; end
      e_lat = 2 + e_busy;
      m_v[s][slot] = 1'b1; m_d[s][slot] = (cmd == CMD_WRITE); m_t[s][slot] = addr[25:4];
      m_stamp++; m_age[s][slot] = m_stamp;
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_req(input logic [1:0] cmd, input logic [25:0] addr,
                        output logic got_hit, output logic [25:0] got_add,
                        output int lat, output int busy);
    int w = 0;
    @(negedge clk);
    while (!bus.ready && w < 50) begin @(negedge clk); w++; end
    bus.cmd_in = cmd; bus.add_in = addr;
    @(posedge clk); #1;
    bus.cmd_in = CMD_IDLE;
    lat = 1; busy = 0;
    while (!bus.resp_valid && lat < 100) begin
      if (mem_busy) busy++;
      @(posedge clk); #1;
      lat++;
    end
    got_hit = bus.resp_hit; got_add = bus.resp_add;
  endtask

  task automatic run_vec(input string tag, input logic [1:0] cmd, input logic [25:0] addr,
                         input logic e_hit, input int e_lat, input int e_busy);
    logic g_hit; logic [25:0] g_add; int g_lat, g_busy;
    do_req(cmd, addr, g_hit, g_add, g_lat, g_busy);
    check({tag, "_hit"},  {63'd0, g_hit}, {63'd0, e_hit});
    check({tag, "_add"},  {38'd0, g_add}, {38'd0, addr});
    check({tag, "_lat"},  64'(g_lat),    64'(e_lat));
    check({tag, "_busy"}, 64'(g_busy),   64'(e_busy));
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.cmd_in = CMD_IDLE; bus.add_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  cmd;
    logic [25:0] addr;
    logic        exp_hit;
    int          exp_lat;
    int          exp_busy;
  } vec_t;

  vec_t tbl [18];

  initial begin
    int pulses;
    bus.cmd_in = CMD_IDLE; bus.add_in = '0;

    // Reset state while rst is held.
    @(negedge clk);
    check("rst_ready",      {63'd0, bus.ready},      64'd1);
    check("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    check("rst_resp_hit",   {63'd0, bus.resp_hit},   64'd0);
    check("rst_resp_add",   {38'd0, bus.resp_add},   64'd0);
    check("rst_mem_busy",   {63'd0, mem_busy},       64'd0);
    check("rst_counters",   {hit, miss | writebacks}, 64'd0);
    rst = 1'b0;

    // Directed vectors (index 0, LRU at index 3, dirty eviction and INVAL
    // at index 5, all-ones tag at index 15).
    tbl[0]  = '{CMD_READ,  mk(22'd1, 4'd0),        1'b0, 6,  4};
    tbl[1]  = '{CMD_READ,  mk(22'd1, 4'd0),        1'b1, 2,  0};
    tbl[2]  = '{CMD_READ,  mk(22'd2, 4'd3),        1'b0, 6,  4};
    tbl[3]  = '{CMD_READ,  mk(22'd3, 4'd3),        1'b0, 6,  4};
    tbl[4]  = '{CMD_READ,  mk(22'd2, 4'd3),        1'b1, 2,  0};
    tbl[5]  = '{CMD_READ,  mk(22'd4, 4'd3),        1'b0, 6,  4};
    tbl[6]  = '{CMD_READ,  mk(22'd3, 4'd3),        1'b0, 6,  4};
    tbl[7]  = '{CMD_WRITE, mk(22'd7, 4'd5),        1'b0, 6,  4};
    tbl[8]  = '{CMD_READ,  mk(22'd8, 4'd5),        1'b0, 6,  4};
    tbl[9]  = '{CMD_READ,  mk(22'd9, 4'd5),        1'b0, 10, 8};
    tbl[10] = '{CMD_INVAL, mk(22'd8, 4'd5),        1'b1, 2,  0};
    tbl[11] = '{CMD_READ,  mk(22'd8, 4'd5),        1'b0, 6,  4};
    tbl[12] = '{CMD_INVAL, mk(22'h3FFFFF, 4'd5),   1'b0, 2,  0};
    tbl[13] = '{CMD_WRITE, mk(22'd8, 4'd5),        1'b1, 2,  0};
    tbl[14] = '{CMD_READ,  mk(22'd16, 4'd5),       1'b0, 6,  4};
    tbl[15] = '{CMD_READ,  mk(22'd17, 4'd5),       1'b0, 10, 8};
    tbl[16] = '{CMD_READ,  mk(22'h3FFFFF, 4'd15),  1'b0, 6,  4};
    tbl[17] = '{CMD_READ,  mk(22'h3FFFFF, 4'd15),  1'b1, 2,  0};

    for (int i = 0; i < 18; i++)
      run_vec($sformatf("vec%0d", i), tbl[i].cmd, tbl[i].addr,
              tbl[i].exp_hit, tbl[i].exp_lat, tbl[i].exp_busy);
    check("tbl_hit_cnt",  64'(hit),        64'd4);
    check("tbl_miss_cnt", 64'(miss),       64'd12);
    check("tbl_wb_cnt",   64'(writebacks), 64'd2);

    // Reset during MEM_WAIT drops the request.
    @(negedge clk);
    bus.cmd_in = CMD_READ; bus.add_in = mk(22'd32, 4'd7);
    @(posedge clk); #1 bus.cmd_in = CMD_IDLE;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_ready",      {63'd0, bus.ready},      64'd1);
    check("midrst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    check("midrst_mem_busy",   {63'd0, mem_busy},       64'd0);
    check("midrst_miss_cnt",   64'(miss),               64'd0);
    @(negedge clk); rst = 1'b0;
    pulses = 0;
    repeat (12) begin @(negedge clk); if (bus.resp_valid) pulses++; end
    check("midrst_no_resp", 64'(pulses), 64'd0);
    run_vec("midrst_reread", CMD_READ, mk(22'd32, 4'd7), 1'b0, 6, 4);
    check("midrst_miss_after", 64'(miss), 64'd1);

    // Commands toggled while ready=0 are ignored.
    @(negedge clk);
    while (!bus.ready) @(negedge clk);
    bus.cmd_in = CMD_READ; bus.add_in = mk(22'd33, 4'd7);
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (bus.resp_valid) pulses++;
      @(negedge clk);
      if (!bus.ready) begin
        bus.cmd_in = 2'($urandom_range(1, 3));
        bus.add_in = 26'($urandom);
      end else begin
        bus.cmd_in = CMD_IDLE;
      end
    end
    check("toggle_one_pulse", 64'(pulses), 64'd1);
    check("toggle_hit_cnt",   64'(hit),    64'd0);
    check("toggle_miss_cnt",  64'(miss),   64'd2);

    // Random traffic against the model.
    do_reset();
    model_reset();
    for (int i = 0; i < 250; i++) begin
      logic [1:0]  cmd;
      logic [25:0] addr;
      logic        e_hit;
      int          e_lat, e_busy, r;
      logic [3:0]  idx_pool [3];
      logic [21:0] tag_pool [4];
      idx_pool[0] = 4'd0; idx_pool[1] = 4'd3; idx_pool[2] = 4'd15;
      tag_pool[0] = 22'd0; tag_pool[1] = 22'd1; tag_pool[2] = 22'd2; tag_pool[3] = 22'h3FFFFF;
      r = int'($urandom_range(0, 9));
      cmd  = (r < 5) ? CMD_READ : (r < 8) ? CMD_WRITE : CMD_INVAL;
      addr = mk(tag_pool[$urandom_range(0, 3)], idx_pool[$urandom_range(0, 2)]);
      model_access(cmd, addr, e_hit, e_lat, e_busy);
      run_vec($sformatf("rnd%0d", i), cmd, addr, e_hit, e_lat, e_busy);
    end
    check("rnd_hit_cnt",  64'(hit),        64'(m_hit));
    check("rnd_miss_cnt", 64'(miss),       64'(m_miss));
    check("rnd_wb_cnt",   64'(writebacks), 64'(m_wb));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
